// File: rtl/sig_gen_sequencer.sv
// Step-table sequencer: replays one generator register write per step, spaced by a programmable tempo.
// Each write holds the strobe STROBE_LEN cycles high, then STROBE_LEN cycles low, so a slow sampler sees it once.
module sig_gen_sequencer #(
    parameter int STEPS      = 8,
    parameter int TEMPO_W    = 16,
    parameter int STROBE_LEN = 128
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       host_we,
    input  logic [3:0] host_addr,
    input  logic [7:0] host_data,
    output logic       gen_strobe,
    output logic [2:0] gen_addr,
    output logic [4:0] gen_data,
    output logic       busy,
    output logic [2:0] step_idx,
    output logic       done
);
    localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int PW = (STROBE_LEN > 1) ? $clog2(STROBE_LEN) : 1;
    localparam logic [PW-1:0] P_LAST    = PW'(STROBE_LEN - 1);
    localparam logic [2:0]    STEP_MASK = 3'(STEPS - 1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SETUP, S_STROBE, S_HOLD} state_t;

    state_t             r_state, w_state_nxt;
    logic [7:0]         r_table [STEPS];
    logic [TEMPO_W-1:0] r_tempo, r_tcnt, w_tcnt_nxt;
    logic [PW-1:0]      r_pcnt, w_pcnt_nxt;
    logic               r_run, r_loop;
    logic [2:0]         r_last, w_last;
    logic [2:0]         r_step, w_step_nxt;
    logic [2:0]         r_gen_addr, w_addr_nxt;
    logic [4:0]         r_gen_data, w_data_nxt;
    logic               r_strobe, r_busy, r_done, w_done_nxt, w_end_run;
    logic               w_wr_table, w_wr_ctrl, w_run_eff;
    logic [15:0]        w_tempo_wide;
    logic [7:0]         w_entry;

    assign w_wr_table = host_we && (host_addr < 4'(STEPS));
    assign w_wr_ctrl  = host_we && (host_addr == 4'd10);
    // A run request written this cycle is honoured immediately so the first strobe lands at E0+tempo+2.
    assign w_run_eff  = w_wr_ctrl ? host_data[0] : r_run;
    assign w_last     = r_last & STEP_MASK;
    assign w_entry    = r_table[r_step[SW-1:0]];

    always_comb begin
        w_tempo_wide = 16'(r_tempo);
        if (host_we && host_addr == 4'd8) w_tempo_wide[7:0]  = host_data;
        if (host_we && host_addr == 4'd9) w_tempo_wide[15:8] = host_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STEPS; i++) r_table[i] <= '0;
            r_tempo <= '0;
            r_run   <= 1'b0;
            r_loop  <= 1'b0;
            r_last  <= '0;
        end else begin
            if (w_wr_table) r_table[host_addr[SW-1:0]] <= host_data;
            r_tempo <= w_tempo_wide[TEMPO_W-1:0];
            if (w_wr_ctrl) begin
                r_run  <= host_data[0];
                r_loop <= host_data[1];
                r_last <= host_data[4:2];
            end else if (w_end_run) begin
                r_run  <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tcnt_nxt  = r_tcnt;
        w_pcnt_nxt  = r_pcnt;
        w_step_nxt  = r_step;
        w_addr_nxt  = r_gen_addr;
        w_data_nxt  = r_gen_data;
        w_done_nxt  = 1'b0;
        w_end_run   = 1'b0;
        if (en) begin
            case (r_state)
                S_IDLE: begin
                    if (w_run_eff) begin
                        w_state_nxt = S_WAIT;
                        w_tcnt_nxt  = r_tempo;
                        w_step_nxt  = '0;
                    end
                end
                S_WAIT: begin
                    if (!r_run) begin
                        w_state_nxt = S_IDLE;
                        w_step_nxt  = '0;
                    end else if (r_tcnt == '0) begin
                        w_state_nxt = S_SETUP;
                    end else begin
                        w_tcnt_nxt  = r_tcnt - TEMPO_W'(1);
                    end
                end
                S_SETUP: begin
                    w_addr_nxt  = w_entry[7:5];
                    w_data_nxt  = w_entry[4:0];
                    w_pcnt_nxt  = '0;
                    w_state_nxt = S_STROBE;
                end
                S_STROBE: begin
                    if (r_pcnt == P_LAST) begin
                        w_pcnt_nxt  = '0;
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_pcnt_nxt  = r_pcnt + PW'(1);
                    end
                end
                S_HOLD: begin
                    if (r_pcnt != P_LAST) begin
                        w_pcnt_nxt = r_pcnt + PW'(1);
                    end else begin
                        w_pcnt_nxt = '0;
                        // A run cleared mid-write only takes effect here, so writes are never truncated.
                        if (!r_run) begin
                            w_state_nxt = S_IDLE;
                            w_step_nxt  = '0;
                        end else if (r_step < w_last) begin
                            w_step_nxt  = r_step + 3'd1;
                            w_tcnt_nxt  = r_tempo;
                            w_state_nxt = S_WAIT;
                        end else if (r_loop) begin
                            w_step_nxt  = '0;
                            w_tcnt_nxt  = r_tempo;
                            w_state_nxt = S_WAIT;
                        end else begin
                            w_done_nxt  = 1'b1;
                            w_end_run   = 1'b1;
                            w_step_nxt  = '0;
                            if (w_wr_ctrl && host_data[0]) begin
                                w_tcnt_nxt  = r_tempo;
                                w_state_nxt = S_WAIT;
                            end else begin
                                w_state_nxt = S_IDLE;
                            end
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_tcnt     <= '0;
            r_pcnt     <= '0;
            r_step     <= '0;
            r_gen_addr <= '0;
            r_gen_data <= '0;
            r_strobe   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tcnt     <= w_tcnt_nxt;
            r_pcnt     <= w_pcnt_nxt;
            r_step     <= w_step_nxt;
            r_gen_addr <= w_addr_nxt;
            r_gen_data <= w_data_nxt;
            r_strobe   <= (w_state_nxt == S_STROBE);
            r_busy     <= (w_state_nxt != S_IDLE);
            r_done     <= w_done_nxt;
        end
    end

    assign gen_strobe = r_strobe;
    assign gen_addr   = r_gen_addr;
    assign gen_data   = r_gen_data;
    assign busy       = r_busy;
    assign step_idx   = r_step;
    assign done       = r_done;
endmodule

// File: tb/tb_sig_gen_sequencer.sv
// Bench for sig_gen_sequencer: directed scenarios plus random single passes checked against a timing/content model.
module tb_sig_gen_sequencer;
    localparam int SL = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       host_we;
    logic [3:0] host_addr;
    logic [7:0] host_data;
    logic       gen_strobe;
    logic [2:0] gen_addr;
    logic [4:0] gen_data;
    logic       busy;
    logic [2:0] step_idx;
    logic       done;

    sig_gen_sequencer #(.STEPS(8), .TEMPO_W(16), .STROBE_LEN(SL)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .host_we(host_we), .host_addr(host_addr),
        .host_data(host_data), .gen_strobe(gen_strobe), .gen_addr(gen_addr), .gen_data(gen_data),
        .busy(busy), .step_idx(step_idx), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    logic [7:0] tbl [8];

    // Observed write events, recorded away from the active edge
    int         rise_t[$];
    logic [2:0] rise_a[$];
    logic [4:0] rise_d[$];
    logic [2:0] rise_s[$];
    int         len_q[$];
    int         done_t[$];
    int         idle_t[$];
    int         unstable = 0;
    int         hi_len = 0;
    logic       prev_stb = 1'b0;
    logic       prev_busy = 1'b0;
    logic [2:0] hold_a;
    logic [4:0] hold_d;

    always @(negedge clk) begin
        if (gen_strobe && !prev_stb) begin
            rise_t.push_back(cyc);
            rise_a.push_back(gen_addr);
            rise_d.push_back(gen_data);
            rise_s.push_back(step_idx);
            hold_a = gen_addr;
            hold_d = gen_data;
            hi_len = 0;
        end
        if (gen_strobe) begin
            hi_len++;
            if (gen_addr !== hold_a || gen_data !== hold_d) unstable++;
        end
        if (!gen_strobe && prev_stb) len_q.push_back(hi_len);
        if (done) done_t.push_back(cyc);
        if (!busy && prev_busy) idle_t.push_back(cyc);
        prev_stb  = gen_strobe;
        prev_busy = busy;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        rise_t.delete(); rise_a.delete(); rise_d.delete(); rise_s.delete();
        len_q.delete(); done_t.delete(); idle_t.delete();
        unstable = 0;
    endtask

    task automatic hw(input logic [3:0] a, input logic [7:0] d);
        host_we = 1'b1; host_addr = a; host_data = d;
        @(posedge clk); #1;
        host_we = 1'b0;
    endtask

    task automatic write_tbl(input int i, input logic [7:0] v);
        tbl[i] = v;
        hw(4'(i), v);
    endtask

    task automatic set_tempo(input int t);
        hw(4'd8, 8'(t));
        hw(4'd9, 8'(t >> 8));
    endtask

    task automatic wait_idle(input int budget);
        int i;
        i = 0;
        while (busy && i < budget) begin
            @(posedge clk); #1;
            i++;
        end
        check("idle_reached", busy, 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic wait_rises(input int n, input int budget);
        int i;
        i = 0;
        while (rise_t.size() < n && i < budget) begin
            @(posedge clk); #1;
            i++;
        end
        check("rise_reached", rise_t.size() >= n, 1);
    endtask

    // Model: step k of a run written at edge e0 rises at e0+T+2+k*(T+2+2*SL) carrying table[k mod (last+1)]
    task automatic run_pass(input int t, input int last);
        int n, p, e0;
        clear_mon();
        set_tempo(t);
        hw(4'd10, 8'((last << 2) | 1));
        e0 = cyc;
        wait_idle(4000);
        n = last + 1;
        p = t + 2 + 2 * SL;
        check("pass_count", rise_t.size(), n);
        check("pass_len_count", len_q.size(), n);
        for (int k = 0; k < n && k < rise_t.size(); k++) begin
            check("pass_rise_t", rise_t[k], e0 + t + 2 + k * p);
            check("pass_addr", rise_a[k], tbl[k][7:5]);
            check("pass_data", rise_d[k], tbl[k][4:0]);
            check("pass_step", rise_s[k], k);
        end
        for (int k = 0; k < len_q.size(); k++) check("pass_len", len_q[k], SL);
        check("pass_stable", unstable, 0);
        check("pass_done_n", done_t.size(), 1);
        if (done_t.size() > 0) check("pass_done_t", done_t[0], e0 + t + 2 + (n - 1) * p + 2 * SL);
        if (idle_t.size() > 0) check("pass_idle_t", idle_t[0], e0 + t + 2 + (n - 1) * p + 2 * SL);
    endtask

    initial begin
        int t, e0, p, r1;
        logic [7:0] old;

        rst_n = 1'b0; en = 1'b1; host_we = 1'b0; host_addr = '0; host_data = '0;
        for (int i = 0; i < 8; i++) tbl[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_strobe", gen_strobe, 0);
        check("rst_busy", busy, 0);
        check("rst_step", step_idx, 0);
        check("rst_done", done, 0);
        check("rst_addr", gen_addr, 0);
        check("rst_data", gen_data, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed single pass: tempo 3, two entries, no loop
        write_tbl(0, 8'h25);
        write_tbl(1, 8'h4A);
        run_pass(3, 1);

        // Random single passes
        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < 8; i++) write_tbl(i, 8'($urandom_range(0, 255)));
            run_pass($urandom_range(0, 12), $urandom_range(0, 7));
        end

        // Loop over 3 entries, stop during the 4th write
        clear_mon();
        for (int i = 0; i < 3; i++) write_tbl(i, 8'($urandom_range(0, 255)));
        t = $urandom_range(0, 6);
        set_tempo(t);
        hw(4'd10, 8'h0B);
        e0 = cyc;
        p = t + 2 + 2 * SL;
        wait_rises(4, 400);
        hw(4'd10, 8'h0A);
        wait_idle(400);
        check("loop_count", rise_t.size(), 4);
        for (int k = 0; k < 4 && k < rise_t.size(); k++) begin
            check("loop_rise_t", rise_t[k], e0 + t + 2 + k * p);
            check("loop_addr", rise_a[k], tbl[k % 3][7:5]);
            check("loop_data", rise_d[k], tbl[k % 3][4:0]);
            check("loop_step", rise_s[k], k % 3);
        end
        for (int k = 0; k < len_q.size(); k++) check("stop_len", len_q[k], SL);
        check("stop_len_count", len_q.size(), 4);
        check("stop_no_done", done_t.size(), 0);
        check("stop_idle_n", idle_t.size(), 1);
        if (idle_t.size() > 0) check("stop_idle_t", idle_t[0], e0 + t + 2 + 3 * p + 2 * SL);

        // Table rewrite while its entry is being strobed
        clear_mon();
        old = 8'($urandom_range(0, 255));
        if (old == 8'h1F) old = 8'h25;
        write_tbl(0, old);
        t = $urandom_range(0, 6);
        set_tempo(t);
        hw(4'd10, 8'h03);
        e0 = cyc;
        p = t + 2 + 2 * SL;
        wait_rises(1, 200);
        write_tbl(0, 8'h1F);
        wait_rises(2, 200);
        hw(4'd10, 8'h02);
        wait_idle(400);
        check("fly_stable", unstable, 0);
        if (rise_t.size() >= 2) begin
            check("fly_addr0", rise_a[0], old[7:5]);
            check("fly_data0", rise_d[0], old[4:0]);
            check("fly_addr1", rise_a[1], 0);
            check("fly_data1", rise_d[1], 31);
            check("fly_step1", rise_s[1], 0);
            check("fly_rise1_t", rise_t[1], e0 + t + 2 + p);
        end
        check("fly_count", rise_t.size(), 2);

        // Enable freeze of 10 cycles mid-WAIT with a tempo write during the freeze
        clear_mon();
        write_tbl(0, 8'($urandom_range(0, 255)));
        write_tbl(1, 8'($urandom_range(0, 255)));
        set_tempo(6);
        hw(4'd10, 8'h05);
        e0 = cyc;
        @(posedge clk); #1;
        en = 1'b0;
        set_tempo(2);
        repeat (8) @(posedge clk);
        #1;
        en = 1'b1;
        wait_idle(400);
        r1 = e0 + 6 + 2 + 10;
        check("frz_count", rise_t.size(), 2);
        if (rise_t.size() >= 2) begin
            check("frz_rise0_t", rise_t[0], r1);
            check("frz_rise1_t", rise_t[1], r1 + 2 + 2 + 2 * SL);
            check("frz_addr1", rise_a[1], tbl[1][7:5]);
            check("frz_data1", rise_d[1], tbl[1][4:0]);
        end
        if (done_t.size() > 0) check("frz_done_t", done_t[0], r1 + 4 + 4 * SL);
        check("frz_done_n", done_t.size(), 1);

        // Asynchronous reset during the second strobe
        clear_mon();
        write_tbl(1, 8'($urandom_range(0, 255)));
        set_tempo(1);
        hw(4'd10, 8'h05);
        wait_rises(2, 300);
        check("pre_rst_strobe", gen_strobe, 1);
        check("pre_rst_step", step_idx, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_strobe", gen_strobe, 0);
        check("arst_busy", busy, 0);
        check("arst_step", step_idx, 0);
        check("arst_addr", gen_addr, 0);
        check("arst_data", gen_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) tbl[i] = 8'h00;
        @(posedge clk); #1;

        // After reset: cleared table and tempo 0 give a write of 0/0 at E0+2
        clear_mon();
        hw(4'd10, 8'h01);
        e0 = cyc;
        wait_idle(400);
        check("post_rst_count", rise_t.size(), 1);
        if (rise_t.size() > 0) begin
            check("post_rst_t", rise_t[0], e0 + 2);
            check("post_rst_addr", rise_a[0], 0);
            check("post_rst_data", rise_d[0], 0);
        end
        if (done_t.size() > 0) check("post_rst_done_t", done_t[0], e0 + 2 + 2 * SL);
        check("post_rst_done_n", done_t.size(), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
